// File: rtl/mmio_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mmio_ctrl_pkg
// Description : Shared constants and helpers for the MMIO control register
//               bank: register word indices, AXI response codes, NOHYPE bits.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_ctrl_pkg;

    // Register word indices (byte offset >> 2); decoded from address bits [4:2]
    localparam logic [2:0] REG_ID       = 3'd0;  // 0x00
    localparam logic [2:0] REG_SCRATCH  = 3'd1;  // 0x04
    localparam logic [2:0] REG_NOHYPE   = 3'd2;  // 0x08
    localparam logic [2:0] REG_CORE_RST = 3'd3;  // 0x0C
    localparam logic [2:0] REG_PENDING  = 3'd4;  // 0x10
    localparam logic [2:0] REG_ENABLE   = 3'd5;  // 0x14
    localparam logic [2:0] REG_CYC_LO   = 3'd6;  // 0x18
    localparam logic [2:0] REG_CYC_HI   = 3'd7;  // 0x1C

    localparam logic [1:0] RESP_OKAY    = 2'b00;
    localparam logic [1:0] RESP_SLVERR  = 2'b10;

    // Bit positions inside nohype_settings
    localparam int NOHYPE_MEM_PART          = 0;
    localparam int NOHYPE_RESET_TO_HANG     = 1;
    localparam int NOHYPE_DISTINCT_HART_DSID = 2;

    // Expand a 4-bit byte strobe into a 32-bit bit mask
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        strb_mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage : mmio_ctrl_pkg
`default_nettype wire

// File: rtl/axilite_wr_join.sv
`default_nettype none
// ============================================================================
// Module      : axilite_wr_join
// Description : Independent 1-deep holding registers for the AXI-Lite AW and W
//               channels, plus the strobe that commits a joined write once
//               both are present and no write response is outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module axilite_wr_join #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_awaddr,
    input  logic              i_awvalid,
    output logic              o_awready,
    input  logic [31:0]       i_wdata,
    input  logic [3:0]        i_wstrb,
    input  logic              i_wvalid,
    output logic              o_wready,
    input  logic              i_resp_busy,
    output logic              o_commit,
    output logic [ADDR_W-1:0] o_addr,
    output logic [31:0]       o_data,
    output logic [3:0]        o_strb
);

    logic              r_aw_full;
    logic              r_w_full;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_data;
    logic [3:0]        r_strb;

    assign o_awready = ~r_aw_full;
    assign o_wready  = ~r_w_full;
    assign o_commit  = r_aw_full & r_w_full & ~i_resp_busy;
    assign o_addr    = r_addr;
    assign o_data    = r_data;
    assign o_strb    = r_strb;

    // Capture AW when empty; release on commit (never both in one cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_full <= 1'b0;
            r_addr    <= '0;
        end else if (i_awvalid && !r_aw_full) begin
            r_aw_full <= 1'b1;
            r_addr    <= i_awaddr;
        end else if (o_commit) begin
            r_aw_full <= 1'b0;
        end
    end

    // Capture W when empty; release on commit together with AW
    always_ff @(posedge clk) begin
        if (rst) begin
            r_w_full <= 1'b0;
            r_data   <= '0;
            r_strb   <= '0;
        end else if (i_wvalid && !r_w_full) begin
            r_w_full <= 1'b1;
            r_data   <= i_wdata;
            r_strb   <= i_wstrb;
        end else if (o_commit) begin
            r_w_full <= 1'b0;
        end
    end

endmodule : axilite_wr_join
`default_nettype wire

// File: rtl/mmio_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : mmio_ctrl_regs
// Description : AXI4-Lite control/status register bank: ID, scratch, nohype
//               settings, per-core reset, interrupt pending/enable and a
//               64-bit cycle counter with a read-snapshot high word.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_ctrl_regs
    import mmio_ctrl_pkg::*;
#(
    parameter int          ADDR_W     = 32,
    parameter logic [31:0] ID_VALUE   = 32'h5041_5244,
    parameter int          NUM_CORES  = 2,
    parameter int          NUM_INTRS  = 2,
    parameter logic [2:0]  NOHYPE_RST = 3'b000
) (
    input  logic                 uncoreclk,
    input  logic                 uncorerst,
    input  logic [ADDR_W-1:0]    s_axilite_awaddr,
    input  logic                 s_axilite_awvalid,
    output logic                 s_axilite_awready,
    input  logic [31:0]          s_axilite_wdata,
    input  logic [3:0]           s_axilite_wstrb,
    input  logic                 s_axilite_wvalid,
    output logic                 s_axilite_wready,
    output logic [1:0]           s_axilite_bresp,
    output logic                 s_axilite_bvalid,
    input  logic                 s_axilite_bready,
    input  logic [ADDR_W-1:0]    s_axilite_araddr,
    input  logic                 s_axilite_arvalid,
    output logic                 s_axilite_arready,
    output logic [31:0]          s_axilite_rdata,
    output logic [1:0]           s_axilite_rresp,
    output logic                 s_axilite_rvalid,
    input  logic                 s_axilite_rready,
    input  logic [NUM_INTRS-1:0] intrs,
    output logic [2:0]           nohype_settings,
    output logic [NUM_CORES-1:0] core_rst,
    output logic                 irq
);

    // ---------------- write join ----------------
    logic              w_commit;
    logic [ADDR_W-1:0] w_cm_addr;
    logic [31:0]       w_cm_data;
    logic [3:0]        w_cm_strb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;

    axilite_wr_join #(.ADDR_W(ADDR_W)) u_wr_join (
        .clk         (uncoreclk),
        .rst         (uncorerst),
        .i_awaddr    (s_axilite_awaddr),
        .i_awvalid   (s_axilite_awvalid),
        .o_awready   (s_axilite_awready),
        .i_wdata     (s_axilite_wdata),
        .i_wstrb     (s_axilite_wstrb),
        .i_wvalid    (s_axilite_wvalid),
        .o_wready    (s_axilite_wready),
        .i_resp_busy (r_bvalid),
        .o_commit    (w_commit),
        .o_addr      (w_cm_addr),
        .o_data      (w_cm_data),
        .o_strb      (w_cm_strb)
    );

    // ---------------- register state ----------------
    logic [31:0]          r_scratch;
    logic [2:0]           r_nohype;
    logic [NUM_CORES-1:0] r_core_rst;
    logic [NUM_INTRS-1:0] r_pending;
    logic [NUM_INTRS-1:0] r_enable;
    logic [NUM_INTRS-1:0] r_intrs_q;
    logic                 r_irq;
    logic [63:0]          r_cyc_cnt;
    logic [31:0]          r_cyc_hi_snap;

    // ---------------- write decode ----------------
    logic [2:0]  w_wr_idx;
    logic        w_wr_oob;
    logic        w_wr_ro;
    logic        w_wr_ok;
    logic [31:0] w_mask;
    logic [31:0] w_nohype_m;
    logic [31:0] w_core_m;
    logic [31:0] w_enable_m;
    logic [31:0] w_clr_m;
    logic [NUM_INTRS-1:0] w_pend_clr;
    logic [NUM_INTRS-1:0] w_pend_set;

    assign w_wr_idx = w_cm_addr[4:2];
    assign w_wr_oob = |w_cm_addr[ADDR_W-1:5];
    assign w_wr_ro  = (w_wr_idx == REG_ID) || (w_wr_idx == REG_CYC_LO) ||
                      (w_wr_idx == REG_CYC_HI);
    assign w_wr_ok  = w_commit & ~w_wr_oob & ~w_wr_ro;
    assign w_mask   = strb_mask(w_cm_strb);

    // Byte-lane merge of new data into each narrow register's old value
    assign w_nohype_m = ({29'd0, r_nohype} & ~w_mask) | (w_cm_data & w_mask);
    assign w_core_m   = ({{(32-NUM_CORES){1'b0}}, r_core_rst} & ~w_mask) | (w_cm_data & w_mask);
    assign w_enable_m = ({{(32-NUM_INTRS){1'b0}}, r_enable} & ~w_mask) | (w_cm_data & w_mask);
    assign w_clr_m    = w_cm_data & w_mask;

    assign w_pend_clr = (w_wr_ok && w_wr_idx == REG_PENDING) ? w_clr_m[NUM_INTRS-1:0] : '0;
    assign w_pend_set = intrs & ~r_intrs_q;

    // Write response: raised the cycle after a commit, held until bready
    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= (w_wr_oob || w_wr_ro) ? RESP_SLVERR : RESP_OKAY;
        end else if (r_bvalid && s_axilite_bready) begin
            r_bvalid <= 1'b0;
        end
    end

    // Writable control registers
    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            r_scratch  <= '0;
            r_nohype   <= NOHYPE_RST;
            r_core_rst <= '1;
            r_enable   <= '0;
        end else if (w_wr_ok) begin
            case (w_wr_idx)
                REG_SCRATCH:  r_scratch  <= (r_scratch & ~w_mask) | (w_cm_data & w_mask);
                REG_NOHYPE:   r_nohype   <= w_nohype_m[2:0];
                REG_CORE_RST: r_core_rst <= w_core_m[NUM_CORES-1:0];
                REG_ENABLE:   r_enable   <= w_enable_m[NUM_INTRS-1:0];
                default: ;
            endcase
        end
    end

    // Interrupt edge detect, pending (set beats clear) and registered irq
    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            r_intrs_q <= '0;
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_intrs_q <= intrs;
            r_pending <= (r_pending & ~w_pend_clr) | w_pend_set;
            r_irq     <= |(r_pending & r_enable);
        end
    end

    // Free-running 64-bit cycle counter, wraps silently
    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            r_cyc_cnt <= '0;
        end else begin
            r_cyc_cnt <= r_cyc_cnt + 64'd1;
        end
    end

    // ---------------- read path ----------------
    logic        r_rvalid;
    logic [31:0] r_rdata;
    logic [1:0]  r_rresp;
    logic [2:0]  w_rd_idx;
    logic        w_rd_oob;
    logic        w_ar_hs;
    logic [31:0] w_rd_data;

    assign w_rd_idx = s_axilite_araddr[4:2];
    assign w_rd_oob = |s_axilite_araddr[ADDR_W-1:5];
    assign w_ar_hs  = s_axilite_arvalid & ~r_rvalid;

    // Read data mux over the current (pre-write) register values
    always_comb begin
        w_rd_data = '0;
        if (!w_rd_oob) begin
            case (w_rd_idx)
                REG_ID:       w_rd_data = ID_VALUE;
                REG_SCRATCH:  w_rd_data = r_scratch;
                REG_NOHYPE:   w_rd_data = {29'd0, r_nohype};
                REG_CORE_RST: w_rd_data = {{(32-NUM_CORES){1'b0}}, r_core_rst};
                REG_PENDING:  w_rd_data = {{(32-NUM_INTRS){1'b0}}, r_pending};
                REG_ENABLE:   w_rd_data = {{(32-NUM_INTRS){1'b0}}, r_enable};
                REG_CYC_LO:   w_rd_data = r_cyc_cnt[31:0];
                REG_CYC_HI:   w_rd_data = r_cyc_hi_snap;
                default:      w_rd_data = '0;
            endcase
        end
    end

    // Registered read response; a CYC_LO read latches the matching high word
    always_ff @(posedge uncoreclk) begin
        if (uncorerst) begin
            r_rvalid      <= 1'b0;
            r_rdata       <= '0;
            r_rresp       <= RESP_OKAY;
            r_cyc_hi_snap <= '0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_oob ? RESP_SLVERR : RESP_OKAY;
            if (!w_rd_oob && w_rd_idx == REG_CYC_LO) begin
                r_cyc_hi_snap <= r_cyc_cnt[63:32];
            end
        end else if (r_rvalid && s_axilite_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign s_axilite_arready = ~r_rvalid;
    assign s_axilite_rvalid  = r_rvalid;
    assign s_axilite_rdata   = r_rdata;
    assign s_axilite_rresp   = r_rresp;
    assign s_axilite_bvalid  = r_bvalid;
    assign s_axilite_bresp   = r_bresp;

    assign nohype_settings[NOHYPE_MEM_PART]           = r_nohype[NOHYPE_MEM_PART];
    assign nohype_settings[NOHYPE_RESET_TO_HANG]      = r_nohype[NOHYPE_RESET_TO_HANG];
    assign nohype_settings[NOHYPE_DISTINCT_HART_DSID] = r_nohype[NOHYPE_DISTINCT_HART_DSID];
    assign core_rst = r_core_rst;
    assign irq      = r_irq;

    // Byte-offset bits and merge upper bits carry no information here
    wire w_unused_bits = &{1'b0, s_axilite_araddr[1:0], w_cm_addr[1:0], w_nohype_m[31:3],
                           w_core_m[31:NUM_CORES], w_enable_m[31:NUM_INTRS],
                           w_clr_m[31:NUM_INTRS]};

endmodule : mmio_ctrl_regs
`default_nettype wire

// File: tb/tb_mmio_ctrl_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_ctrl_regs
// Description : Self-checking bench for mmio_ctrl_regs: a table of single
//               AXI-Lite accesses plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_ctrl_regs;

    localparam logic [31:0] ID = 32'h5041_5244;

    logic        uncoreclk = 1'b0;
    logic        uncorerst;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [1:0]  intrs;
    logic [2:0]  nohype_settings;
    logic [1:0]  core_rst;
    logic        irq;

    int total = 0;
    int bad   = 0;

    always #5 uncoreclk = ~uncoreclk;

    mmio_ctrl_regs dut (
        .uncoreclk         (uncoreclk),
        .uncorerst         (uncorerst),
        .s_axilite_awaddr  (awaddr),
        .s_axilite_awvalid (awvalid),
        .s_axilite_awready (awready),
        .s_axilite_wdata   (wdata),
        .s_axilite_wstrb   (wstrb),
        .s_axilite_wvalid  (wvalid),
        .s_axilite_wready  (wready),
        .s_axilite_bresp   (bresp),
        .s_axilite_bvalid  (bvalid),
        .s_axilite_bready  (bready),
        .s_axilite_araddr  (araddr),
        .s_axilite_arvalid (arvalid),
        .s_axilite_arready (arready),
        .s_axilite_rdata   (rdata),
        .s_axilite_rresp   (rresp),
        .s_axilite_rvalid  (rvalid),
        .s_axilite_rready  (rready),
        .intrs             (intrs),
        .nohype_settings   (nohype_settings),
        .core_rst          (core_rst),
        .irq               (irq)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] ed,
                                input logic [1:0] er, input string n);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.strb = s;
        v.exp_data = ed; v.exp_resp = er; v.name = n;
        return v;
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", n, act, exp);
        end
    endtask

    task automatic timeout_fail(input string n);
        total++;
        bad++;
        $display("FAIL %s: handshake timeout, actual=none required=handshake", n);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs, ok;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        aw_done = 1'b0; w_done = 1'b0; ok = 1'b0; resp = 2'bxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge uncoreclk);
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            @(posedge uncoreclk); #1;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
            if (aw_done && w_done) break;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout_fail("write addr/data");
        end else begin
            for (int i = 0; i < 20; i++) begin
                @(negedge uncoreclk);
                if (bvalid) begin
                    resp = bresp; ok = 1'b1;
                    @(posedge uncoreclk); #1;
                    break;
                end
            end
            if (!ok) timeout_fail("write resp");
        end
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        logic ok, hs;
        araddr = a; arvalid = 1'b1; rready = 1'b1; ok = 1'b0;
        d = 'x; r = 'x;
        for (int i = 0; i < 20; i++) begin
            @(negedge uncoreclk);
            hs = arready;
            @(posedge uncoreclk); #1;
            if (hs) begin ok = 1'b1; break; end
        end
        arvalid = 1'b0;
        if (!ok) begin
            timeout_fail("read addr");
        end else begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge uncoreclk);
                if (rvalid) begin
                    d = rdata; r = rresp; ok = 1'b1;
                    @(posedge uncoreclk); #1;
                    break;
                end
            end
            if (!ok) timeout_fail("read data");
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        // Single-access vectors; state carries from one row to the next
        vecs[0]  = mk(0, 32'h00, 0,            4'h0, ID,           2'b00, "rd ID");
        vecs[1]  = mk(0, 32'h0C, 0,            4'h0, 32'h3,        2'b00, "rd CORE_RST rst");
        vecs[2]  = mk(1, 32'h04, 32'hA5A5A5A5, 4'hF, 0,            2'b00, "wr SCRATCH");
        vecs[3]  = mk(0, 32'h04, 0,            4'h0, 32'hA5A5A5A5, 2'b00, "rd SCRATCH");
        vecs[4]  = mk(1, 32'h24, 32'hDEADBEEF, 4'hF, 0,            2'b10, "wr 0x24");
        vecs[5]  = mk(0, 32'h04, 0,            4'h0, 32'hA5A5A5A5, 2'b00, "rd SCRATCH after 0x24");
        vecs[6]  = mk(0, 32'h24, 0,            4'h0, 32'h0,        2'b10, "rd 0x24");
        vecs[7]  = mk(1, 32'h00, 32'h12345678, 4'hF, 0,            2'b10, "wr ID");
        vecs[8]  = mk(0, 32'h00, 0,            4'h0, ID,           2'b00, "rd ID after wr");
        vecs[9]  = mk(1, 32'h18, 32'h1,        4'hF, 0,            2'b10, "wr CYC_LO");
        vecs[10] = mk(1, 32'h08, 32'hFFFFFFFD, 4'h1, 0,            2'b00, "wr NOHYPE");
        vecs[11] = mk(1, 32'h08, 32'h000000FF, 4'hE, 0,            2'b00, "wr NOHYPE no lane0");
        vecs[12] = mk(0, 32'h08, 0,            4'h0, 32'h5,        2'b00, "rd NOHYPE");
        vecs[13] = mk(1, 32'h0C, 32'h1,        4'hF, 0,            2'b00, "wr CORE_RST");
        vecs[14] = mk(0, 32'h0D, 0,            4'h0, 32'h1,        2'b00, "rd CORE_RST low bits ign");
        vecs[15] = mk(0, 32'h14, 0,            4'h0, 32'h0,        2'b00, "rd ENABLE");

        uncorerst = 1'b1;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b1; intrs = '0;
        repeat (3) @(posedge uncoreclk);
        #1 uncorerst = 1'b0;

        @(negedge uncoreclk);
        check("rst awready", {31'd0, awready}, 32'd1);
        check("rst wready",  {31'd0, wready},  32'd1);
        check("rst arready", {31'd0, arready}, 32'd1);
        check("rst bvalid",  {31'd0, bvalid},  32'd0);
        check("rst rvalid",  {31'd0, rvalid},  32'd0);
        check("rst nohype",  {29'd0, nohype_settings}, 32'd0);
        check("rst core_rst", {30'd0, core_rst}, 32'd3);
        check("rst irq",     {31'd0, irq},     32'd0);
        @(posedge uncoreclk); #1;

        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
                check({vecs[i].name, " resp"}, {30'd0, r}, {30'd0, vecs[i].exp_resp});
            end else begin
                axi_read(vecs[i].addr, d, r);
                check({vecs[i].name, " data"}, d, vecs[i].exp_data);
                check({vecs[i].name, " resp"}, {30'd0, r}, {30'd0, vecs[i].exp_resp});
            end
        end
        check("nohype out", {29'd0, nohype_settings}, 32'h5);
        check("core_rst out", {30'd0, core_rst}, 32'h1);

        // W arrives 3 cycles before AW; partial-strobe merge into scratch
        bready = 1'b1;
        wdata = 32'h11223344; wstrb = 4'b0101; wvalid = 1'b1;
        @(negedge uncoreclk);
        @(posedge uncoreclk); #1 wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge uncoreclk);
            check("early W wready low", {31'd0, wready}, 32'd0);
            check("early W no bvalid", {31'd0, bvalid}, 32'd0);
            @(posedge uncoreclk); #1;
        end
        awaddr = 32'h04; awvalid = 1'b1;
        @(negedge uncoreclk);
        check("late AW awready", {31'd0, awready}, 32'd1);
        @(posedge uncoreclk); #1 awvalid = 1'b0;
        @(negedge uncoreclk);
        check("commit cycle bvalid", {31'd0, bvalid}, 32'd0);
        @(posedge uncoreclk); #1;
        @(negedge uncoreclk);
        check("after commit bvalid", {31'd0, bvalid}, 32'd1);
        check("after commit bresp", {30'd0, bresp}, 32'd0);
        check("after commit wready", {31'd0, wready}, 32'd1);
        @(posedge uncoreclk); #1;
        @(negedge uncoreclk);
        check("B done bvalid", {31'd0, bvalid}, 32'd0);
        axi_read(32'h04, d, r);
        check("strb merge scratch", d, 32'hA522A544);

        // bready low: second write waits in holding regs until B handshake
        bready = 1'b0;
        awaddr = 32'h04; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge uncoreclk);
        @(posedge uncoreclk); #1 awvalid = 1'b0; wvalid = 1'b0;
        @(posedge uncoreclk); #1;
        awaddr = 32'h04; wdata = 32'h2; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge uncoreclk);
        check("held B bvalid", {31'd0, bvalid}, 32'd1);
        check("held B awready", {31'd0, awready}, 32'd1);
        @(posedge uncoreclk); #1 awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge uncoreclk);
            check("held B bvalid stays", {31'd0, bvalid}, 32'd1);
            check("held B aw full", {31'd0, awready}, 32'd0);
            check("held B w full", {31'd0, wready}, 32'd0);
            @(posedge uncoreclk); #1;
        end
        bready = 1'b1;
        @(posedge uncoreclk); #1;
        @(negedge uncoreclk);
        check("post B bvalid low", {31'd0, bvalid}, 32'd0);
        check("post B still full", {31'd0, awready}, 32'd0);
        @(posedge uncoreclk); #1;
        @(negedge uncoreclk);
        check("2nd commit bvalid", {31'd0, bvalid}, 32'd1);
        check("2nd commit awready", {31'd0, awready}, 32'd1);
        @(posedge uncoreclk); #1;
        axi_read(32'h04, d, r);
        check("2nd write data", d, 32'h2);

        // Interrupt pending / enable / irq
        intrs = 2'b10;
        @(posedge uncoreclk); #1 intrs = 2'b00;
        @(posedge uncoreclk); #1;
        axi_read(32'h10, d, r);
        check("pending set", d, 32'h2);
        check("irq masked", {31'd0, irq}, 32'd0);
        axi_write(32'h14, 32'h2, 4'hF, r);
        @(posedge uncoreclk); #1;
        @(negedge uncoreclk);
        check("irq enabled", {31'd0, irq}, 32'd1);
        @(posedge uncoreclk); #1;

        // W1C lands in the same cycle as a new rising edge: set wins
        awaddr = 32'h10; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge uncoreclk);
        @(posedge uncoreclk); #1 awvalid = 1'b0; wvalid = 1'b0; intrs = 2'b10;
        @(posedge uncoreclk); #1;
        @(negedge uncoreclk);
        check("race bvalid", {31'd0, bvalid}, 32'd1);
        @(posedge uncoreclk); #1 intrs = 2'b00;
        axi_read(32'h10, d, r);
        check("set beats clear", d, 32'h2);
        check("irq after race", {31'd0, irq}, 32'd1);
        axi_write(32'h10, 32'h2, 4'hF, r);
        axi_read(32'h10, d, r);
        check("W1C clears", d, 32'h0);
        @(negedge uncoreclk);
        check("irq cleared", {31'd0, irq}, 32'd0);
        @(posedge uncoreclk); #1;

        // Counter snapshot: HI returns value latched by the LO read
        force dut.r_cyc_cnt = 64'h0000_0005_FFFF_FFFF;
        axi_read(32'h18, d, r);
        check("CYC_LO", d, 32'hFFFFFFFF);
        release dut.r_cyc_cnt;
        repeat (3) @(posedge uncoreclk);
        #1;
        axi_read(32'h1C, d, r);
        check("CYC_HI snapshot", d, 32'h5);

        // Reset while a read response is pending
        rready = 1'b0;
        araddr = 32'h00; arvalid = 1'b1;
        @(negedge uncoreclk);
        @(posedge uncoreclk); #1 arvalid = 1'b0;
        @(negedge uncoreclk);
        check("rvalid pending", {31'd0, rvalid}, 32'd1);
        @(posedge uncoreclk); #1 uncorerst = 1'b1;
        @(negedge uncoreclk);
        check("rvalid held", {31'd0, rvalid}, 32'd1);
        @(posedge uncoreclk); #1;
        @(negedge uncoreclk);
        check("reset rvalid", {31'd0, rvalid}, 32'd0);
        check("reset core_rst", {30'd0, core_rst}, 32'd3);
        check("reset nohype", {29'd0, nohype_settings}, 32'd0);
        @(posedge uncoreclk); #1 uncorerst = 1'b0; rready = 1'b1;
        repeat (2) @(posedge uncoreclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mmio_ctrl_regs
`default_nettype wire
